mod_updown_counter: RTL

//   Parametrised modulo-N up/down counter with programmable step, parallel load,
//   and a selectable wrap or saturate mode.

---
 rtl/mod_updown_counter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//
// Modulo-N up/down counter. Features:
//   - programmable step per enabled cycle
//   - parallel load, with the load value clamped to MAX_VAL
//   - compile-time choice of wrap (modulo MAX_VAL+1) or saturate (clamp at
//     0 / MAX_VAL) behaviour
//
// A "limit event" is any update that wraps or clamps. Each limit event raises
// a one-cycle wrap_pulse and sets a sticky overflow flag.
//
// Parameters
//   WIDTH      counter width in bits
//   MAX_VAL    highest legal count (<= 2**WIDTH-1); modulus is MAX_VAL+1
//   STEP_W     width of the step input
//   SATURATE   0 = wrap, 1 = clamp at the limits
//   RESET_VAL  count after reset (<= MAX_VAL)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   en          in   count enable
//   up_down_sw  in   1 = count up, 0 = count down
//   step        in   amount added/subtracted per enabled cycle (clamped to MAX_VAL)
//   load        in   parallel load strobe (overrides en)
//   load_val    in   value loaded when load=1 (clamped to MAX_VAL)
//   clr_ovf     in   clears the sticky overflow flag (a same-cycle event wins)
//   count       out  registered count
//   at_max      out  count == MAX_VAL (combinational)
//   at_min      out  count == 0 (combinational)
//   wrap_pulse  out  registered; high for the cycle after a limit event
//   ovf         out  sticky limit-event flag
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
  parameter int unsigned STEP_W    = 4,
  parameter bit          SATURATE  = 1'b0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              up_down_sw,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              wrap_pulse,
  output logic              ovf
);

  // The step comparison needs to be wide enough to hold both the raw step
  // and MAX_VAL without truncating either.
  localparam int unsigned CW = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;

  localparam logic [CW-1:0]    MAX_C = CW'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_X = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0]   MOD_X = MAX_X + (WIDTH + 1)'(1);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W = WIDTH'(RESET_VAL);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             ovf_q,   ovf_d;

  // ---------------------------------------------------------------------------
  // Datapath
  //
  // All arithmetic is one bit wider than the count. This keeps count+step
  // and count+modulus from overflowing when MAX_VAL = 2**WIDTH-1.
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    step_c;
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   load_x;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH-1:0] load_w;
  logic [WIDTH-1:0] wrap_up_w;
  logic [WIDTH-1:0] wrap_dn_w;
  logic             up_evt;
  logic             dn_evt;
  logic             step_nz;

  assign step_c  = CW'(step);
  assign step_x  = (step_c > MAX_C) ? MAX_X : step_c[WIDTH:0];
  assign step_nz = (step_x != '0);
  assign count_x = {1'b0, count_q};
  assign load_x  = {1'b0, load_val};
  assign load_w  = (load_x > MAX_X) ? MAX_W : load_val;

  assign sum_x   = count_x + step_x;
  assign up_evt  = (sum_x > MAX_X);
  assign dn_evt  = (count_x < step_x);

  // Wrapped results. They are only selected when the matching event is
  // true, so each one always fits in WIDTH bits.
  assign wrap_up_w = WIDTH'(sum_x - MOD_X);
  assign wrap_dn_w = WIDTH'(count_x + MOD_X - step_x);

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: load > en; reset is handled in the register.
  // ---------------------------------------------------------------------------
  // NOTE: every output of a combinational block gets a default before any
  //       branch. A path that leaves one unassigned would infer a latch.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~clr_ovf;

    if (load) begin
      count_d = load_w;
      ovf_d   = 1'b0;
    end else if (en && step_nz) begin
      if (up_down_sw) begin
        if (!up_evt) begin
          count_d = sum_x[WIDTH-1:0];
        end else begin
          count_d = SATURATE ? MAX_W : wrap_up_w;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end
      end else begin
        if (!dn_evt) begin
          count_d = count_q - step_x[WIDTH-1:0];
        end else begin
          count_d = SATURATE ? '0 : wrap_dn_w;
          wrap_d  = 1'b1;
          ovf_d   = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers: synchronous active-low reset.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register then
  //       samples values from before the edge, whatever order they appear in.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= RST_W;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign count      = count_q;
  assign wrap_pulse = wrap_q;
  assign ovf        = ovf_q;
  assign at_max     = (count_q == MAX_W);
  assign at_min     = (count_q == '0);

endmodule
